cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Collects completions from the 8 functional-unit lanes and drives the `SS_SIZE` common-data-bus lanes. These lanes feed the reservation station's `CAM_en` and `CDB_in` ports (and the ROB/map-table wakeup).
- Each FU lane has a small completion FIFO.
- Up to `SS_SIZE` tags are granted per cycle, round-robin.
- An FU whose FIFO is full receives a stall.

Parameters:
- NUM_FU, 8, FU lanes in fixed order: 0-2 ALU, 3 LD, 4 ST, 5-6 MULT, 7 BR.
- SS_SIZE, 3, CDB broadcast lanes per cycle.
- PREG_W, 6, physical-register tag width. RS bit 6 is the ready flag and is not carried here.
- FIFO_DEPTH, 2, completion entries per FU lane (power of 2).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-low reset. Clears when low at posedge clock.
- flush, in, 1, mispredict squash. Discards all pending completions.
- fu_done, in, NUM_FU, FU i completes an instruction this cycle.
- fu_has_dest, in, NUM_FU, the completing instruction writes a physical register.
- fu_tag, in, NUM_FU x PREG_W, destination tag per FU.
- fu_stall, out, NUM_FU, FU i must not assert fu_done next cycle.
- cdb_valid, out, SS_SIZE, lane broadcasts. Connects to RS `CAM_en`.
- cdb_tag, out, SS_SIZE x PREG_W, broadcast tag. Connects to RS `CDB_in`.

Behaviour:
- Reset (reset==0 at posedge): FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, fu_stall=0.
- Enqueue: fu_done[i] & fu_has_dest[i] pushes fu_tag[i] into FIFO i.
  - fu_done with fu_has_dest=0 is dropped and never broadcast (stores, non-linking branches).
- fu_stall[i] = (count_i == FIFO_DEPTH), taken from registered state only.
  - fu_done[i] while fu_stall[i]=1 is a protocol violation. The push is ignored and the FIFO is unchanged.
- Candidate per lane i:
  - The FIFO head if count_i>0.
  - Otherwise a bypass of the incoming push when the FIFO is empty.
  - Minimum latency: fu_done at cycle N gives cdb_valid at cycle N+1.
- Grant:
  - Scan lanes rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Grant the first SS_SIZE lanes that have a candidate.
  - Granted tags are packed into CDB lanes 0..k-1 in scan order.
  - Lanes k..SS_SIZE-1 get cdb_valid=0, cdb_tag=0.
- Outputs cdb_valid and cdb_tag are registered (flopped grant result).
- Dequeue: a granted lane pops its head, or consumes its bypass.
  - A simultaneous push and pop on a non-empty FIFO keeps count unchanged.
- rr_ptr update:
  - Becomes (last granted lane + 1) mod NUM_FU when k>0.
  - Unchanged when k==0.
- Order: tags from one FU are broadcast in completion order. Across FUs, order is by grant only.
- A tag is broadcast exactly once.
- Flush (flush==1 at posedge):
  - All FIFOs are emptied and same-cycle pushes are discarded.
  - cdb_valid=0 next cycle; rr_ptr=0.
  - Flush overrides enqueue and grant.
  - Reset overrides flush.
- Reset asserted mid-stream: pending tags are lost and the next cycle equals the reset state.
- Pointer and count arithmetic is modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.

Optional Feature:
CDB_ARB_STATS_EN
- Defined: adds two outputs.
  - stall_cycles (32): increments each cycle any fu_stall bit is 1.
  - bcast_cnt (32): adds popcount(cdb_valid) each cycle.
  - Both saturate at all-ones, are cleared by reset, and are not cleared by flush.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- sys_defs.vh gets:
  - `PHYS_REG` typedef, `NUM_FU`, `SS_SIZE`, `CDB_FIFO_DEPTH`.
  - FU lane index constants: `FU_IDX_ALU0`..`FU_IDX_BR`.
- Sub-module cdb_fu_fifo: one per FU. Contains push, pop, flush, count, head, empty and full. Instantiated NUM_FU times as an array.
- Grant logic (rotate, priority-pick SS_SIZE, pack) stays in cdb_arbiter.

Test Plan:
1. Reset low 2 cycles, then fu_done[0]=1, fu_has_dest[0]=1, tag 6'd5 at cycle 3.
   - Cycle 4: cdb_valid=3'b001, cdb_tag[0]=5.
2. All 8 fu_done with tags 10..17 in one cycle, rr_ptr=0.
   - Broadcasts 10,11,12 next cycle, then 13,14,15, then 16,17 (lane2 invalid).
   - fu_stall stays 0 throughout.
3. FU 5 pushes tags 20,21,22 on consecutive cycles while lanes 0-4 keep SS_SIZE other candidates pending.
   - fu_stall[5]=1 after two buffered entries.
   - 20,21,22 are eventually broadcast in order.
4. fu_done[4]=1 with fu_has_dest=0, tag 9.
   - No cdb_valid ever for 9.
5. Three FIFOs hold entries, then flush=1 for one cycle concurrent with new fu_done[1].
   - Next cycle: cdb_valid=0 and fu_stall=0.
   - No flushed tag or the concurrent tag is ever broadcast.
6. CDB_ARB_STATS_EN defined, scenario 2 rerun.
   - bcast_cnt=8, stall_cycles=0.
   - Counters survive a flush and clear on reset.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: lane counts, tag type,
// FU lane indices and small helpers used by the grant and statistics logic.
// Optional feature macro: CDB_ARB_STATS_EN (statistics counters in cdb_arbiter).
package cdb_arbiter_pkg;

    localparam int NUM_FU         = 8;
    localparam int SS_SIZE        = 3;
    localparam int PREG_W         = 6;
    localparam int CDB_FIFO_DEPTH = 2;

    localparam int FIFO_PTR_W = $clog2(CDB_FIFO_DEPTH);
    localparam int FIFO_CNT_W = FIFO_PTR_W + 1;
    localparam int FU_IDX_W   = $clog2(NUM_FU);
    localparam int SLOT_W     = $clog2(SS_SIZE + 1);

    typedef logic [PREG_W-1:0] phys_reg_t;

    // Fixed FU lane order as wired into the arbiter
    typedef enum logic [FU_IDX_W-1:0] {
        FU_IDX_ALU0,
        FU_IDX_ALU1,
        FU_IDX_ALU2,
        FU_IDX_LD,
        FU_IDX_ST,
        FU_IDX_MULT0,
        FU_IDX_MULT1,
        FU_IDX_BR
    } fu_idx_e;

    // Lane index after 'lane', wrapping at NUM_FU
    function automatic logic [FU_IDX_W-1:0] next_lane(input logic [FU_IDX_W-1:0] lane);
        return (int'(lane) == NUM_FU - 1) ? '0 : lane + FU_IDX_W'(1);
    endfunction

    // Number of CDB lanes broadcasting in a cycle
    function automatic logic [31:0] lane_popcount(input logic [SS_SIZE-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < SS_SIZE; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-FU completion FIFO holding destination tags waiting for a CDB slot.
// A push while full is ignored; flush empties the FIFO and wins over push/pop.
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  phys_reg_t push_tag,
    input  logic      pop,
    output phys_reg_t head,
    output logic      empty,
    output logic      full
);

    phys_reg_t             mem [CDB_FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_CNT_W-1:0] count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FIFO_CNT_W'(CDB_FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

    // Tag storage; contents only matter while counted as occupied
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers FU completions per lane and broadcasts up
// to SS_SIZE tags per cycle in round-robin order, with an empty-FIFO bypass.
// Optional feature macro: CDB_ARB_STATS_EN adds stall_cycles and bcast_cnt.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_done,
    input  logic [NUM_FU-1:0]              fu_has_dest,
    input  logic [NUM_FU-1:0][PREG_W-1:0]  fu_tag,
    output logic [NUM_FU-1:0]              fu_stall,
    output logic [SS_SIZE-1:0]             cdb_valid,
    output logic [SS_SIZE-1:0][PREG_W-1:0] cdb_tag
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    bcast_cnt
`endif
);

    logic [NUM_FU-1:0]              push_req;
    logic [NUM_FU-1:0]              cand;
    logic [NUM_FU-1:0][PREG_W-1:0]  cand_tag;
    logic [NUM_FU-1:0]              grant;
    logic [NUM_FU-1:0]              fifo_push;
    logic [NUM_FU-1:0]              fifo_pop;
    logic [NUM_FU-1:0]              fifo_empty;
    logic [NUM_FU-1:0]              fifo_full;
    logic [NUM_FU-1:0][PREG_W-1:0]  fifo_head;

    logic [FU_IDX_W-1:0]            rr_ptr;
    logic [FU_IDX_W-1:0]            rr_next;
    logic [FU_IDX_W-1:0]            scan_lane;
    logic [SLOT_W-1:0]              slot;
    logic [SS_SIZE-1:0]             valid_next;
    logic [SS_SIZE-1:0][PREG_W-1:0] tag_next;

    // Stall comes straight from registered occupancy
    assign fu_stall = fifo_full;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_fu_fifo u_fifo (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .push     (fifo_push[i]),
            .push_tag (fu_tag[i]),
            .pop      (fifo_pop[i]),
            .head     (fifo_head[i]),
            .empty    (fifo_empty[i]),
            .full     (fifo_full[i])
        );
    end

    // Per-lane candidate: FIFO head if occupied, else the incoming tag as bypass
    always_comb begin
        push_req = '0;
        cand     = '0;
        cand_tag = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            push_req[i] = fu_done[i] && fu_has_dest[i] && !fifo_full[i];
            cand[i]     = !fifo_empty[i] || push_req[i];
            cand_tag[i] = fifo_empty[i] ? fu_tag[i] : fifo_head[i];
        end
    end

    // Round-robin scan from rr_ptr, granting up to SS_SIZE lanes packed low
    always_comb begin
        grant      = '0;
        valid_next = '0;
        tag_next   = '0;
        rr_next    = rr_ptr;
        slot       = '0;
        scan_lane  = rr_ptr;
        for (int s = 0; s < NUM_FU; s++) begin
            scan_lane = FU_IDX_W'((int'(rr_ptr) + s) % NUM_FU);
            if (cand[scan_lane] && (slot < SLOT_W'(SS_SIZE))) begin
                grant[scan_lane] = 1'b1;
                valid_next[slot] = 1'b1;
                tag_next[slot]   = cand_tag[scan_lane];
                rr_next          = next_lane(scan_lane);
                slot             = slot + SLOT_W'(1);
            end
        end
    end

    // A granted bypass never enters the FIFO; a granted occupied lane pops its head
    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fifo_push[i] = push_req[i] && !(grant[i] && fifo_empty[i]) && !flush;
            fifo_pop[i]  = grant[i] && !fifo_empty[i] && !flush;
        end
    end

    // Registered CDB outputs and round-robin pointer; flush squashes the grant
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= valid_next;
            cdb_tag   <= tag_next;
            rr_ptr    <= rr_next;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [32:0] bcast_sum;

    assign bcast_sum = {1'b0, bcast_cnt} + {1'b0, lane_popcount(cdb_valid)};

    // Saturating activity counters; only reset clears them, flush does not
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cycles <= '0;
            bcast_cnt    <= '0;
        end else begin
            if ((|fu_stall) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            bcast_cnt <= bcast_sum[32] ? '1 : bcast_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a tag scoreboard: expected broadcast
// tags are queued when completions are driven and popped as CDB lanes fire.
// Counter checks are compiled in when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                           clock = 1'b0;
    logic                           reset = 1'b0;
    logic                           flush = 1'b0;
    logic [NUM_FU-1:0]              fu_done = '0;
    logic [NUM_FU-1:0]              fu_has_dest = '0;
    logic [NUM_FU-1:0][PREG_W-1:0]  fu_tag = '0;
    logic [NUM_FU-1:0]              fu_stall;
    logic [SS_SIZE-1:0]             cdb_valid;
    logic [SS_SIZE-1:0][PREG_W-1:0] cdb_tag;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]                    stall_cycles;
    logic [31:0]                    bcast_cnt;
`endif

    int        n_asserts = 0;
    int        n_fails   = 0;
    phys_reg_t exp_q[$];

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .fu_done     (fu_done),
        .fu_has_dest (fu_has_dest),
        .fu_tag      (fu_tag),
        .fu_stall    (fu_stall),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag)
`ifdef CDB_ARB_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .bcast_cnt   (bcast_cnt)
`endif
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Hard stop if the directed sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, required test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [31:0] exp_tag;
        for (int l = 0; l < SS_SIZE; l++) begin
            if (l > 0) begin
                check_eq("cdb_packing", {31'b0, cdb_valid[l] & ~cdb_valid[l-1]}, 32'd0);
            end
            if (cdb_valid[l] === 1'b1) begin
                check_eq("cdb_expected_pending", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_tag = {26'b0, exp_q.pop_front()};
                    check_eq($sformatf("cdb_tag[%0d]", l), {26'b0, cdb_tag[l]}, exp_tag);
                end
            end else begin
                check_eq($sformatf("idle_tag[%0d]", l), {26'b0, cdb_tag[l]}, 32'd0);
            end
        end
    endtask

    task automatic apply_stimulus(input int lane, input int tag, input logic dest);
        fu_done[lane]     = 1'b1;
        fu_has_dest[lane] = dest;
        fu_tag[lane]      = PREG_W'(tag);
    endtask

    task automatic clear_stimulus();
        fu_done     = '0;
        fu_has_dest = '0;
        fu_tag      = '0;
    endtask

    task automatic step_cycle();
        @(posedge clock);
        #1;
        check_output();
    endtask

    task automatic expect_tags(input int t0, input int t1 = -1, input int t2 = -1, input int t3 = -1);
        exp_q.push_back(PREG_W'(t0));
        if (t1 >= 0) exp_q.push_back(PREG_W'(t1));
        if (t2 >= 0) exp_q.push_back(PREG_W'(t2));
        if (t3 >= 0) exp_q.push_back(PREG_W'(t3));
    endtask

    initial begin
        // Reset held low for two cycles
        step_cycle();
        step_cycle();
        check_eq("rst_valid", {29'b0, cdb_valid}, 32'd0);
        check_eq("rst_stall", {24'b0, fu_stall}, 32'd0);
`ifdef CDB_ARB_STATS_EN
        check_eq("rst_stall_cycles", stall_cycles, 32'd0);
        check_eq("rst_bcast_cnt", bcast_cnt, 32'd0);
`endif
        reset = 1'b1;

        // Single completion on ALU0 appears on lane 0 one cycle later
        apply_stimulus(0, 5, 1'b1);
        expect_tags(5);
        step_cycle();
        check_eq("s1_valid", {29'b0, cdb_valid}, 32'd1);
        clear_stimulus();
        step_cycle();
        check_eq("s1_idle", {29'b0, cdb_valid}, 32'd0);

        // Flush with nothing pending returns rr_ptr to 0
        flush = 1'b1;
        step_cycle();
        flush = 1'b0;
        check_eq("s1_flush_valid", {29'b0, cdb_valid}, 32'd0);

        // All eight FUs complete at once: drained 3,3,2 in lane order
        for (int i = 0; i < NUM_FU; i++) apply_stimulus(i, 10 + i, 1'b1);
        for (int i = 0; i < NUM_FU; i++) exp_q.push_back(PREG_W'(10 + i));
        step_cycle();
        check_eq("s2_valid_c1", {29'b0, cdb_valid}, 32'd7);
        check_eq("s2_stall_c1", {24'b0, fu_stall}, 32'd0);
        clear_stimulus();
        step_cycle();
        check_eq("s2_valid_c2", {29'b0, cdb_valid}, 32'd7);
        check_eq("s2_stall_c2", {24'b0, fu_stall}, 32'd0);
        step_cycle();
        check_eq("s2_valid_c3", {29'b0, cdb_valid}, 32'd3);
        check_eq("s2_stall_c3", {24'b0, fu_stall}, 32'd0);
        step_cycle();
        check_eq("s2_valid_c4", {29'b0, cdb_valid}, 32'd0);

        // Lanes 3..5 granted together, moving rr_ptr to 6
        apply_stimulus(3, 40, 1'b1);
        apply_stimulus(4, 41, 1'b1);
        apply_stimulus(5, 42, 1'b1);
        expect_tags(40, 41, 42);
        step_cycle();
        check_eq("prep_valid", {29'b0, cdb_valid}, 32'd7);
        clear_stimulus();

        // MULT0 starved for two grants fills its FIFO and stalls
        apply_stimulus(6, 50, 1'b1);
        apply_stimulus(7, 51, 1'b1);
        apply_stimulus(0, 52, 1'b1);
        apply_stimulus(5, 20, 1'b1);
        expect_tags(50, 51, 52);
        step_cycle();
        check_eq("s3_valid_a", {29'b0, cdb_valid}, 32'd7);
        check_eq("s3_stall_a", {24'b0, fu_stall}, 32'd0);
        clear_stimulus();
        apply_stimulus(1, 53, 1'b1);
        apply_stimulus(2, 54, 1'b1);
        apply_stimulus(3, 55, 1'b1);
        apply_stimulus(5, 21, 1'b1);
        expect_tags(53, 54, 55);
        step_cycle();
        check_eq("s3_valid_b", {29'b0, cdb_valid}, 32'd7);
        check_eq("s3_stall_b", {24'b0, fu_stall}, 32'h20);
        clear_stimulus();
        // Completion while stalled must be ignored (tag 63 never appears)
        apply_stimulus(4, 56, 1'b1);
        apply_stimulus(5, 63, 1'b1);
        expect_tags(56, 20);
        step_cycle();
        check_eq("s3_valid_c", {29'b0, cdb_valid}, 32'd3);
        check_eq("s3_stall_c", {24'b0, fu_stall}, 32'd0);
        clear_stimulus();
        apply_stimulus(5, 22, 1'b1);
        expect_tags(21);
        step_cycle();
        check_eq("s3_valid_d", {29'b0, cdb_valid}, 32'd1);
        clear_stimulus();
        expect_tags(22);
        step_cycle();
        check_eq("s3_valid_e", {29'b0, cdb_valid}, 32'd1);
        step_cycle();
        check_eq("s3_valid_f", {29'b0, cdb_valid}, 32'd0);

        // Completion without a destination is never broadcast
        apply_stimulus(4, 9, 1'b0);
        step_cycle();
        check_eq("s4_valid_1", {29'b0, cdb_valid}, 32'd0);
        clear_stimulus();
        step_cycle();
        check_eq("s4_valid_2", {29'b0, cdb_valid}, 32'd0);

        // Three FIFOs loaded, then flushed alongside a new completion
        for (int i = 0; i < 6; i++) apply_stimulus(i, 24 + i, 1'b1);
        expect_tags(24, 25, 26);
        step_cycle();
        check_eq("s5_valid_load", {29'b0, cdb_valid}, 32'd7);
        clear_stimulus();
        flush = 1'b1;
        apply_stimulus(1, 35, 1'b1);
        step_cycle();
        check_eq("s5_flush_valid", {29'b0, cdb_valid}, 32'd0);
        check_eq("s5_flush_stall", {24'b0, fu_stall}, 32'd0);
        flush = 1'b0;
        clear_stimulus();
        for (int i = 0; i < 3; i++) step_cycle();
        check_eq("s5_after_valid", {29'b0, cdb_valid}, 32'd0);
        // rr_ptr restarts at 0 after flush: lanes 0,1,2 before 7
        apply_stimulus(7, 36, 1'b1);
        apply_stimulus(0, 37, 1'b1);
        apply_stimulus(1, 38, 1'b1);
        apply_stimulus(2, 39, 1'b1);
        expect_tags(37, 38, 39, 36);
        step_cycle();
        check_eq("s5_rr_valid_1", {29'b0, cdb_valid}, 32'd7);
        clear_stimulus();
        step_cycle();
        check_eq("s5_rr_valid_2", {29'b0, cdb_valid}, 32'd1);
        step_cycle();

        // Reset mid-stream drops buffered tags and restarts rr_ptr at 0
        for (int i = 0; i < NUM_FU; i++) apply_stimulus(i, 40 + i, 1'b1);
        expect_tags(40, 41, 42);
        step_cycle();
        check_eq("rst_mid_load", {29'b0, cdb_valid}, 32'd7);
        clear_stimulus();
        reset = 1'b0;
        step_cycle();
        check_eq("rst_mid_valid", {29'b0, cdb_valid}, 32'd0);
        check_eq("rst_mid_stall", {24'b0, fu_stall}, 32'd0);
        reset = 1'b1;
        step_cycle();
        step_cycle();
        apply_stimulus(6, 7, 1'b1);
        apply_stimulus(0, 8, 1'b1);
        expect_tags(8, 7);
        step_cycle();
        check_eq("rst_mid_rr", {29'b0, cdb_valid}, 32'd3);
        clear_stimulus();
        step_cycle();

`ifdef CDB_ARB_STATS_EN
        // Counters: eight broadcasts, no stalls, kept across flush, cleared by reset
        reset = 1'b0;
        step_cycle();
        reset = 1'b1;
        check_eq("st_rst_bcast", bcast_cnt, 32'd0);
        for (int i = 0; i < NUM_FU; i++) apply_stimulus(i, 10 + i, 1'b1);
        for (int i = 0; i < NUM_FU; i++) exp_q.push_back(PREG_W'(10 + i));
        step_cycle();
        clear_stimulus();
        for (int i = 0; i < 4; i++) step_cycle();
        check_eq("st_bcast_cnt", bcast_cnt, 32'd8);
        check_eq("st_stall_cycles", stall_cycles, 32'd0);
        flush = 1'b1;
        step_cycle();
        flush = 1'b0;
        check_eq("st_flush_bcast", bcast_cnt, 32'd8);
        reset = 1'b0;
        step_cycle();
        reset = 1'b1;
        check_eq("st_clear_bcast", bcast_cnt, 32'd0);
        check_eq("st_clear_stall", stall_cycles, 32'd0);
`endif

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
